glyph_blitter: RTL and testbench

//  Next-generation character writer: copies one glyph bitmap from an external glyph ROM into the

---
 rtl/glyph_blitter.sv | 187 ++++++++++++++++++
 tb/tb_glyph_blitter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_blitter.sv
// Glyph blitter: copies one CHAR_WIDTH x CHAR_HEIGHT glyph from a registered glyph ROM into the
// framebuffer at (pos_x, pos_y) with clipping. Optional macro TRANSPARENT_BG_EN skips bit-0 writes.
module glyph_blitter #(
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int CHAR_WIDTH    = 20,
   parameter int CHAR_HEIGHT   = 30,
   parameter int ADDR_W        = 19,
   parameter int COLOR_W       = 3,
   parameter int CODE_W        = 8,
   parameter int X_W           = 10,
   parameter int Y_W           = 9
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               start,
   input  logic [CODE_W-1:0]                  char_code,
   input  logic [X_W-1:0]                     pos_x,
   input  logic [Y_W-1:0]                     pos_y,
   input  logic [COLOR_W-1:0]                 fg_color,
   input  logic [COLOR_W-1:0]                 bg_color,
   output logic                               ready,
   output logic                               done,
   output logic [CODE_W-1:0]                  rom_addr,
   input  logic [CHAR_WIDTH*CHAR_HEIGHT-1:0]  rom_q,
   output logic [ADDR_W-1:0]                  mem_waddr,
   output logic [COLOR_W-1:0]                 mem_wdata,
   output logic                               mem_wenable
);

   localparam int PIX    = CHAR_WIDTH * CHAR_HEIGHT;
   localparam int SLOT_W = $clog2(PIX + 2);
   localparam int COL_W  = $clog2(CHAR_WIDTH + 1);
   localparam int ROW_W  = $clog2(CHAR_HEIGHT + 1);

   localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(PIX - 1);
   localparam logic [SLOT_W-1:0] FINAL_TICK = SLOT_W'(PIX + 1);
   localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(CHAR_WIDTH - 1);
   localparam logic [ADDR_W-1:0] SCREEN_W_A = ADDR_W'(SCREEN_WIDTH);
   localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(SCREEN_WIDTH - (CHAR_WIDTH - 1));
   localparam logic [X_W:0]      X_LIMIT    = (X_W + 1)'(SCREEN_WIDTH);
   localparam logic [Y_W:0]      Y_LIMIT    = (Y_W + 1)'(SCREEN_HEIGHT);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DRAW  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

`ifdef TRANSPARENT_BG_EN
   localparam logic TRANSPARENT_BG = 1'b1;
`else
   localparam logic TRANSPARENT_BG = 1'b0;
`endif

   logic [1:0]         state_r;
   logic [SLOT_W-1:0]  slot_r;
   logic [COL_W-1:0]   col_r;
   logic [ROW_W-1:0]   row_r;
   logic [ADDR_W-1:0]  addr_r;
   logic [X_W-1:0]     x_r;
   logic [Y_W-1:0]     y_r;
   logic [COLOR_W-1:0] fg_r;
   logic [COLOR_W-1:0] bg_r;

   logic               stg_valid_r;
   logic               stg_bit_r;
   logic               stg_clip_r;
   logic [ADDR_W-1:0]  stg_addr_r;

   logic [X_W:0]       col_abs_s;
   logic [Y_W:0]       row_abs_s;
   logic               clip_s;
   logic               in_glyph_s;
   logic               row_end_s;
   logic [SLOT_W-1:0]  bit_idx_s;
   logic               bit_s;

   // Per-slot decode: absolute coordinates (one extra bit so sums never wrap), clip and glyph bit.
   always_comb begin
      col_abs_s  = {1'b0, x_r} + (X_W + 1)'(col_r);
      row_abs_s  = {1'b0, y_r} + (Y_W + 1)'(row_r);
      clip_s     = (col_abs_s >= X_LIMIT) || (row_abs_s >= Y_LIMIT);
      in_glyph_s = (slot_r <= LAST_SLOT);
      row_end_s  = (col_r == LAST_COL);
      bit_idx_s  = LAST_SLOT - slot_r;
      if (in_glyph_s) begin
         bit_s = rom_q[bit_idx_s];
      end else begin
         bit_s = 1'b0;
      end
   end

   // Control FSM, request latch, slot walker and the one-deep slot stage.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         ready       <= 1'b1;
         done        <= 1'b0;
         rom_addr    <= {CODE_W{1'b0}};
         slot_r      <= {SLOT_W{1'b0}};
         col_r       <= {COL_W{1'b0}};
         row_r       <= {ROW_W{1'b0}};
         addr_r      <= {ADDR_W{1'b0}};
         x_r         <= {X_W{1'b0}};
         y_r         <= {Y_W{1'b0}};
         fg_r        <= {COLOR_W{1'b0}};
         bg_r        <= {COLOR_W{1'b0}};
         stg_valid_r <= 1'b0;
         stg_bit_r   <= 1'b0;
         stg_clip_r  <= 1'b0;
         stg_addr_r  <= {ADDR_W{1'b0}};
      end else begin
         done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               stg_valid_r <= 1'b0;
               if (start) begin
                  rom_addr <= char_code;
                  x_r      <= pos_x;
                  y_r      <= pos_y;
                  fg_r     <= fg_color;
                  bg_r     <= bg_color;
                  // Only multiply in the design; DRAW walks the address incrementally.
                  addr_r   <= ADDR_W'(pos_y) * SCREEN_W_A + ADDR_W'(pos_x);
                  ready    <= 1'b0;
                  state_r  <= ST_FETCH;
               end else begin
                  ready <= 1'b1;
               end
            end
            ST_FETCH: begin
               stg_valid_r <= 1'b0;
               slot_r      <= {SLOT_W{1'b0}};
               col_r       <= {COL_W{1'b0}};
               row_r       <= {ROW_W{1'b0}};
               state_r     <= ST_DRAW;
            end
            ST_DRAW: begin
               slot_r      <= slot_r + SLOT_W'(1);
               stg_valid_r <= in_glyph_s;
               stg_bit_r   <= bit_s;
               stg_clip_r  <= clip_s;
               stg_addr_r  <= addr_r;
               if (in_glyph_s) begin
                  if (row_end_s) begin
                     col_r  <= {COL_W{1'b0}};
                     row_r  <= row_r + ROW_W'(1);
                     addr_r <= addr_r + ROW_STEP;
                  end else begin
                     col_r  <= col_r + COL_W'(1);
                     addr_r <= addr_r + ADDR_W'(1);
                  end
               end
               // Two trailing ticks drain the stage and output register before done.
               if (slot_r == FINAL_TICK) begin
                  done    <= 1'b1;
                  state_r <= ST_DONE;
               end
            end
            ST_DONE: begin
               stg_valid_r <= 1'b0;
               ready       <= 1'b1;
               state_r     <= ST_IDLE;
            end
            default: begin
               stg_valid_r <= 1'b0;
               ready       <= 1'b1;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   // Framebuffer write port register.
   always_ff @(posedge clock) begin
      if (reset) begin
         mem_wenable <= 1'b0;
         mem_waddr   <= {ADDR_W{1'b0}};
         mem_wdata   <= {COLOR_W{1'b0}};
      end else begin
         mem_wenable <= stg_valid_r & ~stg_clip_r & (stg_bit_r | ~TRANSPARENT_BG);
         mem_waddr   <= stg_addr_r;
         mem_wdata   <= stg_bit_r ? fg_r : bg_r;
      end
   end

endmodule

// File: tb/tb_glyph_blitter.sv
// Self-checking bench for glyph_blitter: directed scenarios plus random glyphs/positions checked
// against a behavioural pixel-list model.
module tb_glyph_blitter;

   localparam int SW  = 640;
   localparam int SH  = 480;
   localparam int CW  = 20;
   localparam int CH  = 30;
   localparam int PIX = CW * CH;
   localparam int LAT = PIX + 3;

`ifdef TRANSPARENT_BG_EN
   localparam bit TRANSP = 1'b1;
`else
   localparam bit TRANSP = 1'b0;
`endif

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic           start = 1'b0;
   logic [7:0]     char_code = 8'd0;
   logic [9:0]     pos_x = 10'd0;
   logic [8:0]     pos_y = 9'd0;
   logic [2:0]     fg_color = 3'd0;
   logic [2:0]     bg_color = 3'd0;
   logic           ready;
   logic           done;
   logic [7:0]     rom_addr;
   logic [PIX-1:0] rom_q;
   logic [18:0]    mem_waddr;
   logic [2:0]     mem_wdata;
   logic           mem_wenable;

   logic [PIX-1:0] rom_mem [0:255];
   logic [21:0]    got_q[$];
   logic [21:0]    exp_q[$];
   int             checks = 0;
   int             failures = 0;
   int             cyc = 0;
   int             acc_cyc = -1;
   int             done_cnt = 0;
   int             last_done_cyc = -1;

   glyph_blitter dut (
      .clock(clock), .reset(reset), .start(start), .char_code(char_code),
      .pos_x(pos_x), .pos_y(pos_y), .fg_color(fg_color), .bg_color(bg_color),
      .ready(ready), .done(done), .rom_addr(rom_addr), .rom_q(rom_q),
      .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wenable(mem_wenable)
   );

   always #5 clock = ~clock;

   always @(posedge clock) rom_q <= rom_mem[rom_addr];

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (!reset && start && ready) acc_cyc <= cyc + 1;
   end

   always @(negedge clock) begin
      if (mem_wenable) got_q.push_back({mem_waddr, mem_wdata});
      if (done) begin
         done_cnt      <= done_cnt + 1;
         last_done_cyc <= cyc;
      end
   end

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
      end
   endtask

   task automatic build_exp(input logic [7:0] code, input int x, input int y,
                            input logic [2:0] fg, input logic [2:0] bg);
      logic [PIX-1:0] g;
      logic           b;
      logic [18:0]    a;
      g = rom_mem[code];
      exp_q.delete();
      for (int r = 0; r < CH; r++) begin
         for (int c = 0; c < CW; c++) begin
            b = g[PIX-1-(r*CW+c)];
            if ((x + c < SW) && (y + r < SH) && (b || !TRANSP)) begin
               a = 19'((y + r) * SW + x + c);
               exp_q.push_back({a, b ? fg : bg});
            end
         end
      end
   endtask

   task automatic launch(input logic [7:0] code, input int x, input int y,
                         input logic [2:0] fg, input logic [2:0] bg);
      build_exp(code, x, y, fg, bg);
      got_q.delete();
      char_code = code;
      pos_x     = 10'(x);
      pos_y     = 9'(y);
      fg_color  = fg;
      bg_color  = bg;
      start     = 1'b1;
      step();
      start = 1'b0;
      check("accept_ready_low", ready, 0);
   endtask

   task automatic wait_done();
      int n;
      int d0;
      n  = 0;
      d0 = done_cnt;
      while (done_cnt == d0 && n < 2000) begin
         step();
         n++;
      end
      check("done_seen", (done_cnt != d0), 1);
      check("done_latency", last_done_cyc - acc_cyc, LAT);
      step();
      check("done_width", done, 0);
      check("ready_after_done", ready, 1);
      check("single_done", done_cnt - d0, 1);
   endtask

   task automatic compare_writes(input string tag);
      int mm;
      int n;
      mm = 0;
      n  = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) mm++;
      check({tag, "_content"}, mm, 0);
   endtask

   task automatic first_last(output logic [63:0] fa, output logic [63:0] la);
      if (got_q.size() > 0) begin
         fa = 64'(got_q[0][21:3]);
         la = 64'(got_q[got_q.size()-1][21:3]);
      end else begin
         fa = 'x;
         la = 'x;
      end
   endtask

   initial begin
      logic [607:0] t;
      logic [63:0]  fa;
      logic [63:0]  la;
      int           d0;
      int           a0;
      int           n;
      int           mm;
      int           x;
      int           y;

      for (int k = 0; k < 256; k++) begin
         for (int w = 0; w < 19; w++) t[w*32 +: 32] = $urandom;
         rom_mem[k] = t[PIX-1:0];
      end
      rom_mem[8'h41] = '1;
      for (int r = 0; r < CH; r++)
         for (int c = 0; c < CW; c++)
            rom_mem[8'h55][PIX-1-(r*CW+c)] = ((r + c) % 2 == 0);

      // Reset state
      reset = 1'b1;
      step();
      step();
      check("rst_ready", ready, 1);
      check("rst_done", done, 0);
      check("rst_wen", mem_wenable, 0);
      check("rst_waddr", mem_waddr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_rom_addr", rom_addr, 0);
      reset = 1'b0;
      step();

      // Full glyph of ones at origin
      launch(8'h41, 0, 0, 3'd7, 3'd2);
      check("ones_rom_addr", rom_addr, 8'h41);
      wait_done();
      compare_writes("ones");
      first_last(fa, la);
      check("ones_first_addr", fa, 0);
      check("ones_last_addr", la, 18579);

      // Right-edge clipping
      launch(8'h41, 630, 0, 3'd5, 3'd1);
      wait_done();
      compare_writes("clip_x");
      first_last(fa, la);
      check("clip_x_n", got_q.size(), 300);
      check("clip_x_first", fa, 630);

      // Bottom-edge clipping
      launch(8'h41, 0, 470, 3'd6, 3'd1);
      wait_done();
      compare_writes("clip_y");
      first_last(fa, la);
      check("clip_y_n", got_q.size(), 200);
      check("clip_y_last", la, 306579);

      // Checkerboard: alternating fg/bg, or fg only when background is transparent
      launch(8'h55, 100, 50, 3'd3, 3'd4);
      wait_done();
      compare_writes("checker");
      check("checker_n", got_q.size(), TRANSP ? 300 : 600);

      // Random glyphs, colours and positions (some straddling the edges)
      for (int i = 0; i < 5; i++) begin
         x = (i % 2 == 1) ? int'($urandom_range(600, 700)) : int'($urandom_range(0, 639));
         y = (i % 3 == 2) ? int'($urandom_range(440, 511)) : int'($urandom_range(0, 479));
         launch(8'($urandom), x, y, 3'($urandom), 3'($urandom));
         wait_done();
         compare_writes("random");
      end

      // Start pulsed mid-DRAW is ignored
      launch(8'h41, 200, 200, 3'd1, 3'd0);
      repeat (200) step();
      a0        = acc_cyc;
      char_code = 8'h55;
      start     = 1'b1;
      step();
      start = 1'b0;
      wait_done();
      compare_writes("middraw");
      d0 = done_cnt;
      repeat (650) step();
      check("middraw_no_2nd_done", done_cnt, d0);
      check("middraw_no_2nd_accept", acc_cyc, a0);
      check("middraw_idle_ready", ready, 1);

      // Start held through done: second glyph accepted as soon as ready returns
      build_exp(8'h41, 10, 20, 3'd2, 3'd5);
      got_q.delete();
      char_code = 8'h41;
      pos_x     = 10'd10;
      pos_y     = 9'd20;
      fg_color  = 3'd2;
      bg_color  = 3'd5;
      start     = 1'b1;
      step();
      char_code = 8'h55;
      pos_x     = 10'd300;
      pos_y     = 9'd300;
      fg_color  = 3'd6;
      bg_color  = 3'd1;
      wait_done();
      compare_writes("hold_a");
      build_exp(8'h55, 300, 300, 3'd6, 3'd1);
      got_q.delete();
      step();
      start = 1'b0;
      check("hold_b_accept_cycle", acc_cyc, last_done_cyc + 2);
      check("hold_b_ready_low", ready, 0);
      wait_done();
      compare_writes("hold_b");

      // Reset during DRAW
      launch(8'h41, 0, 0, 3'd7, 3'd0);
      n = 0;
      while (got_q.size() < 100 && n < 400) begin
         step();
         n++;
      end
      check("rst_draw_reached", (got_q.size() >= 100), 1);
      reset = 1'b1;
      step();
      check("rst_draw_wen", mem_wenable, 0);
      check("rst_draw_ready", ready, 1);
      check("rst_draw_done", done, 0);
      reset = 1'b0;
      mm = 0;
      for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) mm++;
      check("rst_draw_prefix", mm, 0);
      n  = got_q.size();
      d0 = done_cnt;
      repeat (650) step();
      check("rst_draw_no_done", done_cnt, d0);
      check("rst_draw_no_writes", got_q.size(), n);

      // Reset and start together: reset wins
      got_q.delete();
      d0        = done_cnt;
      char_code = 8'h41;
      reset     = 1'b1;
      start     = 1'b1;
      step();
      reset = 1'b0;
      start = 1'b0;
      check("rst_start_ready0", ready, 1);
      step();
      check("rst_start_ready1", ready, 1);
      repeat (20) step();
      check("rst_start_no_writes", got_q.size(), 0);
      check("rst_start_no_done", done_cnt, d0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
